// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants for the reg_file slice: default geometry and the index
//   of the hardwired-zero register, plus a small address helper used by the
//   read ports and the write decoder.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NUM_REGS_DEF = 2 ** ADDR_W_DEF;
  localparam int unsigned ZERO_REG     = 0;

  // An address names a storage register when it is in range and not the
  // hardwired-zero slot.
  function automatic logic addr_is_live(input int unsigned addr,
                                        input int unsigned num_regs);
    return (addr != ZERO_REG) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
//   One asynchronous read port of reg_file. Selects a register from the
//   packed register image, forces 0 for the zero register, out-of-range
//   addresses and while rst is high.
//   Optional macro: REG_FILE_BYPASS_EN -- forward wdata when raddr matches a
//   non-zero waddr (write-through).
// Ports:
//   rst    in  1                 asynchronous active-high reset (output gate)
//   raddr  in  ADDR_W            read address
//   regs   in  NUM_REGS*DATA_W   current register contents
//   waddr  in  ADDR_W            write address (forwarding only)
//   wdata  in  DATA_W            write data (forwarding only)
//   rdata  out DATA_W            read data
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [DATA_W-1:0]                wdata,
  output logic [DATA_W-1:0]                rdata
);

  logic [DATA_W-1:0] sel_data;

  // Loop mux rather than a direct index so addresses >= NUM_REGS fall
  // through to 0 without an out-of-bounds select.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(raddr) == i) begin
        sel_data = regs[i];
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rdata = '0;
    if (!rst) begin
      if ((raddr == waddr) && (32'(waddr) != ZERO_REG)) begin
        rdata = wdata;
      end else if (addr_is_live(32'(raddr), NUM_REGS)) begin
        rdata = sel_data;
      end
    end
  end
`else
  // Write-side inputs are only consumed by the forwarding build.
  logic bypass_unused;
  assign bypass_unused = ^{waddr, wdata};

  always_comb begin
    rdata = '0;
    if (!rst && addr_is_live(32'(raddr), NUM_REGS)) begin
      rdata = sel_data;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// reg_file
//   NUM_REGS x DATA_W register file, two asynchronous read ports, one write
//   port written on every rising clk edge (no write enable). Register 0 is
//   hardwired to zero; out-of-range writes are dropped and reads return 0.
//   Optional macro: REG_FILE_BYPASS_EN -- read ports forward D1 when their
//   address matches a non-zero W1.
// Ports:
//   clk   in  1       rising-edge clock
//   rst   in  1       asynchronous active-high reset, clears all registers
//   R1    in  ADDR_W  read address, port 1
//   R2    in  ADDR_W  read address, port 2
//   W1    in  ADDR_W  write address
//   D1    in  DATA_W  write data
//   Out1  out DATA_W  read data for R1
//   Out2  out DATA_W  read data for R2
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] W1,
  input  logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  // Slot ZERO_REG is never loaded, so it keeps its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((32'(W1) == i) && addr_is_live(i, NUM_REGS)) begin
        regs_d[i] = D1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port1 (
    .rst   (rst),
    .raddr (R1),
    .regs  (regs_q),
    .waddr (W1),
    .wdata (D1),
    .rdata (Out1)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port2 (
    .rst   (rst),
    .raddr (R2),
    .regs  (regs_q),
    .waddr (W1),
    .wdata (D1),
    .rdata (Out2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Directed test of reg_file with default geometry (32 x 32 bits).
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic [4:0]  W1;
  logic [31:0] D1;
  logic [31:0] Out1;
  logic [31:0] Out2;

  int total;
  int bad;

  reg_file dut (
    .clk  (clk),
    .rst  (rst),
    .R1   (R1),
    .R2   (R2),
    .W1   (W1),
    .D1   (D1),
    .Out1 (Out1),
    .Out2 (Out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a write for exactly one rising edge, then park W1 on register 0
  // so idle edges write nothing.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    W1 = a;
    D1 = d;
    @(posedge clk);
    #1;
    W1 = '0;
    D1 = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_pre;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    R1    = 5'd5;
    R2    = 5'd31;
    W1    = '0;
    D1    = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out1", Out1, 32'h0);
    chk("rst_out2", Out2, 32'h0);

    // Edge while rst is high must not write.
    @(negedge clk);
    W1 = 5'd5;
    D1 = 32'h1234;
    @(posedge clk);
    #1;
    W1 = '0;
    D1 = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_suppress_write", Out1, 32'h0);

    write_reg(5'd5, 32'd32);
    R1 = 5'd5;
    R2 = 5'd2;
    #1;
    chk("w5_out1", Out1, 32'd32);
    chk("w5_out2", Out2, 32'd0);

    write_reg(5'd2, 32'd50);
    #1;
    chk("w2_out1", Out1, 32'd32);
    chk("w2_out2", Out2, 32'd50);
    R1 = 5'd2;
    #1;
    chk("same_addr_out1", Out1, 32'd50);
    chk("same_addr_out2", Out2, 32'd50);

    write_reg(5'd0, 32'hFFFF_FFFF);
    R1 = 5'd0;
    R2 = 5'd0;
    #1;
    chk("zero_reg_out1", Out1, 32'h0);
    chk("zero_reg_out2", Out2, 32'h0);

    write_reg(5'd31, 32'hDEAD_BEEF);
    R2 = 5'd31;
    #1;
    chk("top_reg_out2", Out2, 32'hDEAD_BEEF);

    // Read-during-write: old value unless forwarding is built in.
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 32'd9;
`else
    exp_pre = 32'd0;
`endif
    @(negedge clk);
    W1 = 5'd7;
    D1 = 32'd9;
    R1 = 5'd7;
    #1;
    chk("rdw_pre_edge", Out1, exp_pre);
    @(posedge clk);
    #1;
    chk("rdw_post_edge", Out1, 32'd9);
    W1 = '0;
    D1 = '0;
    #1;
    chk("rdw_hold", Out1, 32'd9);

    // Async reset between edges, aborting a pending write to register 4.
    write_reg(5'd3, 32'h0000_00A5);
    R1 = 5'd3;
    #1;
    chk("w3_out1", Out1, 32'h0000_00A5);
    @(negedge clk);
    W1 = 5'd4;
    D1 = 32'd77;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out1", Out1, 32'h0);
    chk("async_rst_out2", Out2, 32'h0);
    @(posedge clk);
    #1;
    W1 = '0;
    D1 = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      R1 = 5'(a);
      R2 = 5'(31 - a);
      #1;
      chk($sformatf("cleared_out1_r%0d", a), Out1, 32'h0);
      chk($sformatf("cleared_out2_r%0d", 31 - a), Out2, 32'h0);
    end

    // Register file is usable again after reset.
    write_reg(5'd4, 32'h0BAD_F00D);
    R1 = 5'd4;
    R2 = 5'd3;
    #1;
    chk("post_rst_w4_out1", Out1, 32'h0BAD_F00D);
    chk("post_rst_w4_out2", Out2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 2**ADDR_W (32), number of architectural registers.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 SHALL have port order: clk, rst, R1, R2, W1, D1, Out1, Out2.
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port R1, input, ADDR_W bits, read address for port 1.
REQ-009 SHALL have port R2, input, ADDR_W bits, read address for port 2.
REQ-010 SHALL have port W1, input, ADDR_W bits, write address.
REQ-011 SHALL have port D1, input, DATA_W bits, write data.
REQ-012 SHALL have port Out1, output, DATA_W bits, read data for R1.
REQ-013 SHALL have port Out2, output, DATA_W bits, read data for R2.

Function
REQ-014 SHALL hold NUM_REGS registers of DATA_W bits, addressed 0..NUM_REGS-1.
REQ-015 SHALL write D1 into register W1 on every rising clk edge while rst is low; there is no write-enable port.
REQ-016 SHALL treat register 0 as hardwired zero: writes with W1=0 are discarded, and reads of address 0 return 0.
REQ-017 SHALL make Out1/Out2 combinational (asynchronous) reads of registers R1/R2, with zero-cycle latency from an address change.
REQ-018 SHALL permit R1=R2 with both outputs returning the same value.
REQ-019 SHALL return 0 on reads of addresses >= NUM_REGS and ignore writes to such addresses (relevant only when NUM_REGS < 2**ADDR_W).
REQ-020 SHALL, without bypass, return the pre-edge value when a read address equals W1 during the write cycle; the new value appears after the edge.

Reset
REQ-021 SHALL clear all registers to 0 immediately on rst high, independent of clk.
REQ-022 SHALL drive Out1=Out2=0 while rst is high, for any R1/R2.
REQ-023 SHALL suppress writes while rst is high; the first write occurs on the first rising edge after rst deasserts.
REQ-024 SHALL discard a write aborted by rst asserting mid-cycle; the register reads 0.

Configuration
REQ-025 SHALL support macro REG_FILE_BYPASS_EN.
REQ-026 SHALL, with REG_FILE_BYPASS_EN defined, drive OutN=D1 combinationally when RN==W1, W1!=0 and rst is low (write-through forwarding).
REQ-027 SHALL, without REG_FILE_BYPASS_EN, behave per REQ-020 with no forwarding logic.

Structure
REQ-028 SHALL place the DATA_W, ADDR_W and NUM_REGS defaults and the zero-register index constant in package reg_file_pkg.
REQ-029 SHALL implement each read port as one instance of sub-module reg_file_rd_port, instantiated twice; the sub-module contains the mux, zero/range check and optional bypass.

Verification
REQ-030 Pulse rst with registers previously written -> Out1=Out2=0 for all addresses.
REQ-031 W1=5, D1=32 with one rising edge, then R1=5, R2=2 -> Out1=32, Out2=0.
REQ-032 With register 5 holding 32, apply W1=2, D1=50 with one edge, R1=5, R2=2 -> Out1=32, Out2=50.
REQ-033 W1=0, D1=0xFFFFFFFF with one edge, R1=0 -> Out1=0.
REQ-034 Hold W1=7, D1=9, R1=7 before the edge -> Out1=9 with REG_FILE_BYPASS_EN, old value (0) without; 9 after the edge in both builds.
REQ-035 Assert rst between edges after writing 0xA5 to register 3 -> Out1 (R1=3) drops to 0 before the next edge.
